// File: rtl/spi_cmd_ctrl_if.sv
// Signal bundle between the SPI frame side, the register bus and status outputs.
// The controller uses the master view; the environment (SPI slave, bus, monitor) uses slave.
interface spi_cmd_ctrl_if;
  logic        flag_done;
  logic [15:0] rxd_data;
  logic [15:0] txd_data;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        busy;
  logic        err;
  logic [7:0]  frame_cnt;

  modport master (
    input  flag_done, rxd_data, bus_ack, bus_rdata,
    output txd_data, bus_req, bus_we, bus_addr, bus_wdata, busy, err, frame_cnt
  );

  modport slave (
    output flag_done, rxd_data, bus_ack, bus_rdata,
    input  txd_data, bus_req, bus_we, bus_addr, bus_wdata, busy, err, frame_cnt
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Decodes 16-bit SPI command frames into register-bus accesses, with a bus timeout,
// sticky error flags and an internal status/control register at address 7'h7F.
module spi_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  spi_cmd_ctrl_if.master   sif
);

  typedef enum logic [1:0] {IDLE, BUS_WR, BUS_RD} state_t;

  localparam logic [6:0] INT_ADDR     = 7'h7F;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [6:0]  bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [15:0] txd_q, txd_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_err_q, overrun_err_d;
  logic [5:0]  wait_q, wait_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        rx_rw;
  logic [6:0]  rx_addr;
  logic [7:0]  rx_data;
  logic        wait_expired;

  assign rx_rw        = sif.rxd_data[15];
  assign rx_addr      = sif.rxd_data[14:8];
  assign rx_data      = sif.rxd_data[7:0];
  assign wait_expired = ({2'b00, wait_q} == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 7'h00;
      bus_wdata_q   <= 8'h00;
      txd_q         <= 16'h0000;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      wait_q        <= 6'd0;
      frame_cnt_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      txd_q         <= txd_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      wait_q        <= wait_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    txd_d         = txd_q;
    timeout_err_d = timeout_err_q;
    overrun_err_d = overrun_err_q;
    wait_d        = wait_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (sif.flag_done) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          txd_d       = 16'h0000;
          if (sif.rxd_data == 16'h0000) begin
            txd_d = 16'h0000;
          end else if (rx_addr == INT_ADDR) begin
            // The internal register is served locally and never reaches the bus.
            if (rx_rw) begin
              txd_d = {1'b1, INT_ADDR, timeout_err_q, overrun_err_q, 6'b000000};
            end else if (rx_data[0]) begin
              timeout_err_d = 1'b0;
              overrun_err_d = 1'b0;
            end
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = ~rx_rw;
            bus_addr_d = rx_addr;
            wait_d     = 6'd0;
            if (!rx_rw) begin
              bus_wdata_d = rx_data;
            end
            state_d = rx_rw ? BUS_RD : BUS_WR;
          end
        end
      end
      BUS_WR, BUS_RD: begin
        if (sif.flag_done) begin
          overrun_err_d = 1'b1;
        end
        // An ack on the last allowed cycle wins over the timeout.
        if (sif.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUS_RD) begin
            txd_d = {1'b1, bus_addr_q, sif.bus_rdata};
          end
        end else if (wait_expired) begin
          bus_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
          if (state_q == BUS_RD) begin
            txd_d = {1'b0, bus_addr_q, 8'h00};
          end
        end else begin
          wait_d = wait_q + 6'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  assign sif.txd_data  = txd_q;
  assign sif.bus_req   = bus_req_q;
  assign sif.bus_we    = bus_we_q;
  assign sif.bus_addr  = bus_addr_q;
  assign sif.bus_wdata = bus_wdata_q;
  assign sif.busy      = (state_q != IDLE);
  assign sif.err       = timeout_err_q | overrun_err_q;
  assign sif.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed scenarios plus randomized frames,
// compared against a transaction-level model of frame decoding and bus outcomes.
module tb_spi_cmd_ctrl;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  spi_cmd_ctrl_if sif();

  spi_cmd_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  // Transaction-level model state
  logic [15:0] m_txd;
  logic [7:0]  m_cnt;
  logic        m_to, m_ov, m_we;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_txd = 16'h0; m_cnt = 8'h0; m_to = 1'b0; m_ov = 1'b0;
    m_we = 1'b0; m_addr = 7'h0; m_wdata = 8'h0;
  endtask

  // Effect of a frame accepted while the controller is idle
  task automatic model_accept(input logic [15:0] f);
    m_cnt = m_cnt + 8'd1;
    if (f == 16'h0000) begin
      m_txd = 16'h0000;
    end else if (f[14:8] == 7'h7F) begin
      if (f[15]) begin
        m_txd = {1'b1, 7'h7F, m_to, m_ov, 6'b0};
      end else begin
        m_txd = 16'h0000;
        if (f[0]) begin m_to = 1'b0; m_ov = 1'b0; end
      end
    end else begin
      m_txd  = 16'h0000;
      m_we   = ~f[15];
      m_addr = f[14:8];
      if (!f[15]) m_wdata = f[7:0];
    end
  endtask

  // Outcome of a bus access: acked within T cycles succeeds, otherwise it times out
  task automatic model_bus(input logic rw, input int lat, input logic [7:0] rdata, input logic ovr);
    if (ovr) m_ov = 1'b1;
    if (lat <= T - 1) begin
      if (rw) m_txd = {1'b1, m_addr, rdata};
    end else begin
      m_to = 1'b1;
      if (rw) m_txd = {1'b0, m_addr, 8'h00};
    end
  endtask

  function automatic int exp_req_cycles(input int lat);
    return (lat <= T - 1) ? lat + 1 : T;
  endfunction

  task automatic send_frame(input logic [15:0] f);
    sif.flag_done = 1'b1;
    sif.rxd_data  = f;
    tick();
    sif.flag_done = 1'b0;
    sif.rxd_data  = 16'($urandom);
  endtask

  // Plays the bus slave: acks on cycle lat of the request, optionally injects a frame
  // at cycle ovr_at; reports request length and cycles where bus fields were wrong.
  task automatic drive_bus(input int lat, input logic [7:0] rdata, input int ovr_at,
                           input logic exp_we, input logic [6:0] exp_addr,
                           input logic [7:0] exp_wdata, input logic chk_wdata,
                           output int req_cycles, output int bad_cycles);
    req_cycles = 0;
    bad_cycles = 0;
    for (int c = 0; c < 300; c++) begin
      if (sif.bus_req !== 1'b1) break;
      req_cycles++;
      if (sif.bus_we !== exp_we || sif.bus_addr !== exp_addr ||
          (chk_wdata && sif.bus_wdata !== exp_wdata)) bad_cycles++;
      sif.bus_ack   = (c == lat);
      sif.bus_rdata = rdata;
      sif.flag_done = (c == ovr_at);
      sif.rxd_data  = 16'($urandom);
      tick();
      sif.bus_ack   = 1'b0;
      sif.flag_done = 1'b0;
      sif.bus_rdata = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    checks++; if (sif.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", sif.bus_req); end
    checks++; if ({sif.bus_we, sif.bus_addr, sif.bus_wdata} !== 16'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h want 0", {sif.bus_we, sif.bus_addr, sif.bus_wdata}); end
    checks++; if (sif.txd_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_txd: got %h want 0", sif.txd_data); end
    checks++; if ({sif.busy, sif.err, sif.frame_cnt} !== 10'h0) begin errors++; $display("[TB] FAIL reset_status: got %h want 0", {sif.busy, sif.err, sif.frame_cnt}); end
  endtask

  task automatic test_write();
    int rc, bad;
    send_frame(16'h1234);
    model_accept(16'h1234);
    checks++; if (sif.busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy: got %b want 1", sif.busy); end
    drive_bus(3, 8'h00, -1, 1'b1, 7'h12, 8'h34, 1'b1, rc, bad);
    model_bus(1'b0, 3, 8'h00, 1'b0);
    checks++; if (rc !== 4) begin errors++; $display("[TB] FAIL write_req_len: got %0d want 4", rc); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL write_fields: got %0d bad cycles want 0", bad); end
    checks++; if (sif.frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL write_cnt: got %0d want 1", sif.frame_cnt); end
    checks++; if ({sif.err, sif.busy, sif.bus_req} !== 3'b000) begin errors++; $display("[TB] FAIL write_end: got %b want 000", {sif.err, sif.busy, sif.bus_req}); end
  endtask

  task automatic test_read();
    int rc, bad;
    send_frame(16'h8A00);
    model_accept(16'h8A00);
    drive_bus(2, 8'h5C, -1, 1'b0, 7'h0A, 8'h00, 1'b0, rc, bad);
    model_bus(1'b1, 2, 8'h5C, 1'b0);
    checks++; if (rc !== 3 || bad !== 0) begin errors++; $display("[TB] FAIL read_req: got len %0d bad %0d want 3/0", rc, bad); end
    checks++; if (sif.txd_data !== 16'h8A5C) begin errors++; $display("[TB] FAIL read_txd: got %h want 8a5c", sif.txd_data); end
    // A stray ack while idle must be ignored
    sif.bus_ack = 1'b1; sif.bus_rdata = 8'hAA;
    tick();
    sif.bus_ack = 1'b0;
    checks++; if (sif.txd_data !== m_txd || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: got txd %h busy %b want %h 0", sif.txd_data, sif.busy, m_txd); end
    send_frame(16'h0000);
    model_accept(16'h0000);
    checks++; if (sif.txd_data !== 16'h0000) begin errors++; $display("[TB] FAIL nop_txd: got %h want 0", sif.txd_data); end
    checks++; if (sif.frame_cnt !== m_cnt) begin errors++; $display("[TB] FAIL nop_cnt: got %0d want %0d", sif.frame_cnt, m_cnt); end
  endtask

  task automatic test_timeout();
    int rc, bad;
    send_frame(16'h8500);
    model_accept(16'h8500);
    drive_bus(1000, 8'h00, -1, 1'b0, 7'h05, 8'h00, 1'b0, rc, bad);
    model_bus(1'b1, 1000, 8'h00, 1'b0);
    checks++; if (rc !== T) begin errors++; $display("[TB] FAIL timeout_len: got %0d want %0d", rc, T); end
    checks++; if (sif.txd_data !== 16'h0500) begin errors++; $display("[TB] FAIL timeout_txd: got %h want 0500", sif.txd_data); end
    checks++; if (sif.err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b want 1", sif.err); end
    send_frame(16'h7F00);
    model_accept(16'h7F00);
    checks++; if (sif.err !== 1'b1 || sif.txd_data !== 16'h0) begin errors++; $display("[TB] FAIL noclear: got err %b txd %h want 1 0000", sif.err, sif.txd_data); end
    send_frame(16'hFF00);
    model_accept(16'hFF00);
    checks++; if (sif.txd_data !== 16'hFF80) begin errors++; $display("[TB] FAIL status_read: got %h want ff80", sif.txd_data); end
    send_frame(16'h7F01);
    model_accept(16'h7F01);
    checks++; if (sif.err !== 1'b0 || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_err: got err %b busy %b want 0 0", sif.err, sif.busy); end
  endtask

  task automatic test_ack_at_limit();
    int rc, bad;
    send_frame(16'hB300);
    model_accept(16'hB300);
    drive_bus(T - 1, 8'h99, -1, 1'b0, 7'h33, 8'h00, 1'b0, rc, bad);
    model_bus(1'b1, T - 1, 8'h99, 1'b0);
    checks++; if (rc !== T) begin errors++; $display("[TB] FAIL limit_len: got %0d want %0d", rc, T); end
    checks++; if (sif.txd_data !== 16'hB399) begin errors++; $display("[TB] FAIL limit_txd: got %h want b399", sif.txd_data); end
    checks++; if (sif.err !== 1'b0) begin errors++; $display("[TB] FAIL limit_err: got %b want 0", sif.err); end
  endtask

  task automatic test_overrun();
    int rc, bad;
    logic [7:0] cnt_before;
    send_frame(16'h2255);
    model_accept(16'h2255);
    cnt_before = m_cnt;
    drive_bus(5, 8'h00, 2, 1'b1, 7'h22, 8'h55, 1'b1, rc, bad);
    model_bus(1'b0, 5, 8'h00, 1'b1);
    checks++; if (rc !== 6 || bad !== 0) begin errors++; $display("[TB] FAIL overrun_req: got len %0d bad %0d want 6/0", rc, bad); end
    checks++; if (sif.frame_cnt !== cnt_before) begin errors++; $display("[TB] FAIL overrun_cnt: got %0d want %0d", sif.frame_cnt, cnt_before); end
    checks++; if (sif.err !== 1'b1) begin errors++; $display("[TB] FAIL overrun_err: got %b want 1", sif.err); end
    send_frame(16'h7F01);
    model_accept(16'h7F01);
    checks++; if (sif.err !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b want 0", sif.err); end
    // Frame arriving in the very cycle of the ack
    send_frame(16'h9100);
    model_accept(16'h9100);
    drive_bus(4, 8'h3C, 4, 1'b0, 7'h11, 8'h00, 1'b0, rc, bad);
    model_bus(1'b1, 4, 8'h3C, 1'b1);
    checks++; if (rc !== 5 || sif.txd_data !== 16'h913C) begin errors++; $display("[TB] FAIL overrun_ack: got len %0d txd %h want 5 913c", rc, sif.txd_data); end
    checks++; if (sif.err !== 1'b1 || sif.frame_cnt !== m_cnt) begin errors++; $display("[TB] FAIL overrun_ack_st: got err %b cnt %0d want 1 %0d", sif.err, sif.frame_cnt, m_cnt); end
  endtask

  task automatic test_random();
    int rc, bad, lat, ovr, kind, erc;
    logic [15:0] f;
    logic [7:0]  rdata;
    logic        is_bus;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      f = 16'($urandom);
      if (kind == 0) f = 16'h0000;
      else if (kind == 1) f = {1'b1, 7'h7F, 8'($urandom)};
      else if (kind == 2) f = {1'b0, 7'h7F, 8'($urandom)};
      is_bus = (f != 16'h0000) && (f[14:8] != 7'h7F);
      send_frame(f);
      model_accept(f);
      if (is_bus) begin
        lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 8));
        erc   = exp_req_cycles(lat);
        ovr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, erc - 1)) : -1;
        rdata = 8'($urandom);
        drive_bus(lat, rdata, ovr, ~f[15], f[14:8], f[7:0], ~f[15], rc, bad);
        model_bus(f[15], lat, rdata, ovr >= 0);
        checks++; if (rc !== erc || bad !== 0) begin errors++; $display("[TB] FAIL rnd_req[%0d]: frame %h got len %0d bad %0d want %0d/0", i, f, rc, bad, erc); end
      end else begin
        checks++; if (sif.bus_req !== 1'b0 || sif.bus_addr !== m_addr || sif.bus_we !== m_we) begin errors++; $display("[TB] FAIL rnd_idle[%0d]: frame %h got req %b addr %h we %b want 0 %h %b", i, f, sif.bus_req, sif.bus_addr, sif.bus_we, m_addr, m_we); end
      end
      checks++; if (sif.txd_data !== m_txd) begin errors++; $display("[TB] FAIL rnd_txd[%0d]: frame %h got %h want %h", i, f, sif.txd_data, m_txd); end
      checks++; if (sif.frame_cnt !== m_cnt || sif.err !== (m_to | m_ov) || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL rnd_status[%0d]: got cnt %0d err %b busy %b want %0d %b 0", i, sif.frame_cnt, sif.err, sif.busy, m_cnt, m_to | m_ov); end
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 255; i++) begin
      send_frame(16'h0000);
      model_accept(16'h0000);
    end
    checks++; if (sif.frame_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_ff: got %h want ff", sif.frame_cnt); end
    send_frame(16'h0000);
    model_accept(16'h0000);
    checks++; if (sif.frame_cnt !== 8'h00) begin errors++; $display("[TB] FAIL wrap_00: got %h want 00", sif.frame_cnt); end
  endtask

  task automatic test_reset_mid();
    send_frame(16'hC4AB);
    checks++; if (sif.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_start: got %b want 1", sif.bus_req); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    checks++; if (sif.bus_req !== 1'b0 || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_req: got req %b busy %b want 0 0", sif.bus_req, sif.busy); end
    checks++; if ({sif.txd_data, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.err, sif.frame_cnt} !== 41'h0) begin errors++; $display("[TB] FAIL mid_outputs: got %h want 0", {sif.txd_data, sif.bus_we, sif.bus_addr, sif.bus_wdata, sif.err, sif.frame_cnt}); end
    sif.bus_ack = 1'b1; sif.bus_rdata = 8'h77;
    tick();
    sif.bus_ack = 1'b0;
    tick();
    checks++; if (sif.txd_data !== m_txd || sif.bus_req !== 1'b0 || sif.busy !== 1'b0) begin errors++; $display("[TB] FAIL late_ack: got txd %h req %b busy %b want %h 0 0", sif.txd_data, sif.bus_req, sif.busy, m_txd); end
  endtask

  initial begin
    rst = 1'b1;
    sif.flag_done = 1'b0;
    sif.rxd_data  = 16'h0;
    sif.bus_ack   = 1'b0;
    sif.bus_rdata = 8'h0;
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_limit();
    test_overrun();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
